// File: rtl/teak_action_control.sv
// teak_action_control
//   AXI4-Lite register slave that launches a kernel action through a
//   four-phase go/done handshake and hands it a 64-bit parameter base.
//
// Ports
//   clk, reset_n          : system clock, async active-low reset
//   s_axi_aw*/w*/b*       : AXI4-Lite write channels (32-bit addr/data)
//   s_axi_ar*/r*          : AXI4-Lite read channels
//   go_0r  / go_0a        : start request / acknowledge
//   done_0r / done_0a     : completion request / acknowledge
//   param_buf_base        : parameter buffer base to the action
//   interrupt             : level interrupt, GIE & ISR
//
// Register map (addr[5:2]): 0x00 CTRL {idle,done,start}, 0x04 GIE,
//   0x08 IER, 0x0C ISR (W1C), 0x10 PARAM_LO, 0x14 PARAM_HI.
module teak_action_control #(
  parameter logic [63:0] PARAM_RESET_BASE = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        go_0r,
  input  logic        go_0a,
  input  logic        done_0r,
  output logic        done_0a,
  output logic [63:0] param_buf_base,
  output logic        interrupt
);

  typedef enum logic [2:0] {S_IDLE, S_GO, S_RUN, S_ACK, S_DRAIN} state_e;

  localparam logic [3:0] A_CTRL = 4'd0;
  localparam logic [3:0] A_GIE  = 4'd1;
  localparam logic [3:0] A_IER  = 4'd2;
  localparam logic [3:0] A_ISR  = 4'd3;
  localparam logic [3:0] A_PLO  = 4'd4;
  localparam logic [3:0] A_PHI  = 4'd5;

  state_e      state_q, state_d;
  logic        wr_rdy_q, wr_rdy_d;
  logic        bvalid_q, bvalid_d;
  logic        ar_rdy_q, ar_rdy_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        gie_q, gie_d;
  logic        ier_q, ier_d;
  logic        isr_q, isr_d;
  logic        done_q, done_d;
  logic        irq_q, irq_d;
  logic [63:0] param_q, param_d;

  logic        wr_fire, rd_fire, start_wr, complete, idle;
  logic [3:0]  wr_idx, rd_idx;
  logic [31:0] rd_mux;

  // Only addr[5:2] is decoded; the rest of the address is don't-care.
  logic unused_addr;
  assign unused_addr = ^{s_axi_awaddr[31:6], s_axi_awaddr[1:0],
                         s_axi_araddr[31:6], s_axi_araddr[1:0]};

  assign wr_idx   = s_axi_awaddr[5:2];
  assign rd_idx   = s_axi_araddr[5:2];
  // Ready is raised for one cycle only once both channels are valid, so the
  // handshake completes on the cycle the registered ready is high.
  assign wr_fire  = wr_rdy_q & s_axi_awvalid & s_axi_wvalid;
  assign rd_fire  = ar_rdy_q & s_axi_arvalid;
  assign idle     = (state_q == S_IDLE);
  assign complete = (state_q == S_ACK);
  assign start_wr = wr_fire & (wr_idx == A_CTRL) & s_axi_wstrb[0] & s_axi_wdata[0];

  always_comb begin
    rd_mux = 32'h0;
    case (rd_idx)
      A_CTRL:  rd_mux = {29'b0, idle, done_q, ~idle};
      A_GIE:   rd_mux = {31'b0, gie_q};
      A_IER:   rd_mux = {31'b0, ier_q};
      A_ISR:   rd_mux = {31'b0, isr_q};
      A_PLO:   rd_mux = param_q[31:0];
      A_PHI:   rd_mux = param_q[63:32];
      default: rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    wr_rdy_d = ~wr_rdy_q & ~bvalid_q & s_axi_awvalid & s_axi_wvalid;
    bvalid_d = bvalid_q;
    if (wr_fire)                        bvalid_d = 1'b1;
    else if (bvalid_q && s_axi_bready)  bvalid_d = 1'b0;

    ar_rdy_d = ~ar_rdy_q & ~rvalid_q & s_axi_arvalid;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end

    gie_d = gie_q;
    ier_d = ier_q;
    if (wr_fire && s_axi_wstrb[0] && wr_idx == A_GIE) gie_d = s_axi_wdata[0];
    if (wr_fire && s_axi_wstrb[0] && wr_idx == A_IER) ier_d = s_axi_wdata[0];

    // Completion wins over a same-cycle clear for both status bits.
    isr_d = isr_q;
    if (complete && ier_q)
      isr_d = 1'b1;
    else if (wr_fire && s_axi_wstrb[0] && wr_idx == A_ISR && s_axi_wdata[0])
      isr_d = 1'b0;

    done_d = done_q;
    if (complete)                         done_d = 1'b1;
    else if (rd_fire && rd_idx == A_CTRL) done_d = 1'b0;

    irq_d = gie_q & isr_q;

    // Parameter base is frozen while an action is in flight.
    param_d = param_q;
    for (int b = 0; b < 4; b++) begin
      if (wr_fire && idle && s_axi_wstrb[b]) begin
        if (wr_idx == A_PLO) param_d[8*b +: 8]      = s_axi_wdata[8*b +: 8];
        if (wr_idx == A_PHI) param_d[32 + 8*b +: 8] = s_axi_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_wr) state_d = S_GO;
      S_GO:    if (go_0a)    state_d = S_RUN;
      S_RUN:   if (done_0r)  state_d = S_ACK;
      S_ACK:                 state_d = S_DRAIN;
      S_DRAIN: if (!done_0r) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      wr_rdy_q <= 1'b0;
      bvalid_q <= 1'b0;
      ar_rdy_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      gie_q    <= 1'b0;
      ier_q    <= 1'b0;
      isr_q    <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      param_q  <= PARAM_RESET_BASE;
    end else begin
      state_q  <= state_d;
      wr_rdy_q <= wr_rdy_d;
      bvalid_q <= bvalid_d;
      ar_rdy_q <= ar_rdy_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      gie_q    <= gie_d;
      ier_q    <= ier_d;
      isr_q    <= isr_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
      param_q  <= param_d;
    end
  end

  // Handshake outputs decode straight from the state register.
  assign go_0r          = (state_q == S_GO);
  assign done_0a        = (state_q == S_ACK);
  assign s_axi_awready  = wr_rdy_q;
  assign s_axi_wready   = wr_rdy_q;
  assign s_axi_bvalid   = bvalid_q;
  assign s_axi_bresp    = 2'b00;
  assign s_axi_arready  = ar_rdy_q;
  assign s_axi_rvalid   = rvalid_q;
  assign s_axi_rdata    = rdata_q;
  assign s_axi_rresp    = 2'b00;
  assign param_buf_base = param_q;
  assign interrupt      = irq_q;

endmodule

// File: tb/tb_teak_action_control.sv
module tb_teak_action_control;
  localparam logic [63:0] RB = 64'h0000_00AB_0000_0040;
  localparam logic [31:0] A_CTRL = 32'h00, A_GIE = 32'h04, A_IER = 32'h08,
                          A_ISR = 32'h0C, A_PLO = 32'h10, A_PHI = 32'h14;

  logic clk = 0, reset_n = 0;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [3:0]  wstrb = 0;
  logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic arvalid = 0, arready, rvalid, rready = 0;
  logic [1:0] bresp, rresp;
  logic go_0r, go_0a, done_0r, done_0a, interrupt;
  logic [63:0] pbase;
  logic stub_en = 1, go_man = 0, done_man = 0, done_stub;

  int total = 0, bad = 0;
  int go_hi = 0, go_rise = 0, dn_hi = 0, dn_rise = 0;
  logic go_prev = 0, dn_prev = 0;

  always #5 clk = ~clk;

  assign go_0a   = stub_en ? go_0r : go_man;
  assign done_0r = stub_en ? done_stub : done_man;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) done_stub <= 1'b0;
    else if (stub_en && go_0r && go_0a) done_stub <= 1'b1;
    else if (done_0a) done_stub <= 1'b0;

  always @(negedge clk) begin
    go_prev <= go_0r;
    dn_prev <= done_0a;
    if (go_0r) go_hi <= go_hi + 1;
    if (go_0r && !go_prev) go_rise <= go_rise + 1;
    if (done_0a) dn_hi <= dn_hi + 1;
    if (done_0a && !dn_prev) dn_rise <= dn_rise + 1;
  end

  teak_action_control #(.PARAM_RESET_BASE(RB)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .go_0r(go_0r), .go_0a(go_0a), .done_0r(done_0r), .done_0a(done_0a),
    .param_buf_base(pbase), .interrupt(interrupt));

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    total++;
    if (!(awready && wready)) begin bad++; $display("FAIL wr_accept addr=%h ready=%b/%b want 1/1", a, awready, wready); end
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    total++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin bad++; $display("FAIL wr_resp addr=%h bvalid=%b bresp=%0d want 1/0", a, bvalid, bresp); end
    @(negedge clk);
    bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    total++;
    if (!arready) begin bad++; $display("FAIL rd_accept addr=%h arready=0 want 1", a); end
    @(negedge clk);
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    total++;
    if (rvalid !== 1'b1 || rresp !== 2'b00) begin bad++; $display("FAIL rd_resp addr=%h rvalid=%b rresp=%0d want 1/0", a, rvalid, rresp); end
    d = rdata;
    @(negedge clk);
    rready = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({go_0r, done_0a, interrupt, awready, wready, bvalid, arready, rvalid} !== 8'b0 || rdata !== 32'h0) begin
      bad++; $display("FAIL reset_outs got=%b rdata=%h want 0", {go_0r, done_0a, interrupt, awready, wready, bvalid, arready, rvalid}, rdata);
    end
    total++;
    if (pbase !== RB) begin bad++; $display("FAIL reset_param got=%h want %h", pbase, RB); end
    reset_n = 1;
    axi_read(A_CTRL, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL reset_ctrl got=%h want 4", d); end
    axi_read(A_GIE, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_gie got=%h want 0", d); end
    axi_read(A_ISR, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_isr got=%h want 0", d); end
    axi_read(32'h3C, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_rd got=%h want 0", d); end
  endtask

  task automatic test_param();
    logic [31:0] d;
    axi_write(A_PLO, 32'h1000, 4'hF);
    axi_write(A_PHI, 32'h2, 4'hF);
    total++;
    if (pbase !== 64'h0000_0002_0000_1000) begin bad++; $display("FAIL param_full got=%h want 0000000200001000", pbase); end
    axi_write(A_PLO, 32'hAABB_CCDD, 4'b0010);
    axi_read(A_PLO, d);
    total++; if (d !== 32'h0000_CC00) begin bad++; $display("FAIL param_byte got=%h want 0000cc00", d); end
    axi_write(32'h38, 32'hFFFF_FFFF, 4'hF);
    axi_write(A_PLO, 32'h1000, 4'hF);
    total++;
    if (pbase !== 64'h0000_0002_0000_1000) begin bad++; $display("FAIL param_restore got=%h want 0000000200001000", pbase); end
  endtask

  task automatic test_run();
    logic [31:0] d;
    int gh, gr, dh, dr;
    gh = go_hi; gr = go_rise; dh = dn_hi; dr = dn_rise;
    axi_write(A_CTRL, 32'h1, 4'hF);
    repeat (10) @(negedge clk);
    total++;
    if (go_rise - gr != 1 || go_hi - gh != 1) begin bad++; $display("FAIL run_go rises=%0d cycles=%0d want 1/1", go_rise - gr, go_hi - gh); end
    total++;
    if (dn_rise - dr != 1 || dn_hi - dh != 1) begin bad++; $display("FAIL run_done rises=%0d cycles=%0d want 1/1", dn_rise - dr, dn_hi - dh); end
    axi_read(A_CTRL, d);
    total++; if (d !== 32'h6) begin bad++; $display("FAIL run_ctrl1 got=%h want 6", d); end
    axi_read(A_CTRL, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL run_ctrl2 got=%h want 4", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    axi_write(A_GIE, 32'h1, 4'hF);
    axi_write(A_IER, 32'h1, 4'hF);
    axi_write(A_CTRL, 32'h1, 4'hF);
    repeat (10) @(negedge clk);
    total++; if (interrupt !== 1'b1) begin bad++; $display("FAIL irq_set got=%b want 1", interrupt); end
    axi_read(A_ISR, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL isr_set got=%h want 1", d); end
    axi_write(A_ISR, 32'h1, 4'hF);
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL irq_clr got=%b want 0", interrupt); end
    axi_read(A_CTRL, d);
    axi_write(A_IER, 32'h0, 4'hF);
    axi_write(A_CTRL, 32'h1, 4'hF);
    repeat (10) @(negedge clk);
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b want 0", interrupt); end
    axi_read(A_ISR, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL isr_masked got=%h want 0", d); end
    axi_read(A_CTRL, d);
    total++; if (d !== 32'h6) begin bad++; $display("FAIL masked_ctrl got=%h want 6", d); end
    axi_write(A_GIE, 32'h0, 4'hF);
  endtask

  task automatic test_busy();
    logic [31:0] d;
    int gr, dr;
    stub_en = 0; go_man = 0; done_man = 0;
    axi_write(A_CTRL, 32'h1, 4'hF);
    total++; if (go_0r !== 1'b1) begin bad++; $display("FAIL busy_go_hold got=%b want 1", go_0r); end
    go_man = 1;
    @(negedge clk);
    go_man = 0;
    total++; if (go_0r !== 1'b0) begin bad++; $display("FAIL busy_go_drop got=%b want 0", go_0r); end
    gr = go_rise; dr = dn_rise;
    axi_write(A_CTRL, 32'h1, 4'hF);
    axi_write(A_PLO, 32'hFFFF, 4'hF);
    repeat (3) @(negedge clk);
    total++; if (go_rise != gr || go_0r !== 1'b0) begin bad++; $display("FAIL busy_restart rises=%0d go=%b want 0/0", go_rise - gr, go_0r); end
    total++;
    if (pbase !== 64'h0000_0002_0000_1000) begin bad++; $display("FAIL busy_param got=%h want 0000000200001000", pbase); end
    axi_read(A_CTRL, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL busy_ctrl got=%h want 1", d); end
    done_man = 1;
    repeat (4) @(negedge clk);
    done_man = 0;
    repeat (3) @(negedge clk);
    total++; if (dn_rise - dr != 1) begin bad++; $display("FAIL busy_done rises=%0d want 1", dn_rise - dr); end
    axi_read(A_CTRL, d);
    total++; if (d !== 32'h6) begin bad++; $display("FAIL busy_end_ctrl got=%h want 6", d); end
    stub_en = 1;
  endtask

  task automatic test_aw_only();
    int acc, brise;
    logic bprev;
    @(negedge clk);
    awaddr = A_GIE; wdata = 0; wstrb = 4'hF; awvalid = 1; wvalid = 0; bready = 1;
    acc = 0;
    repeat (5) begin
      @(negedge clk);
      if (awready || wready) acc++;
    end
    total++; if (acc != 0) begin bad++; $display("FAIL aw_only_ready cycles=%0d want 0", acc); end
    wvalid = 1; acc = 0; brise = 0; bprev = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (awready) acc++;
      else if (acc > 0) begin awvalid = 0; wvalid = 0; end
      if (bvalid && !bprev) brise++;
      bprev = bvalid;
    end
    awvalid = 0; wvalid = 0; bready = 0;
    total++; if (acc != 1 || brise != 1) begin bad++; $display("FAIL aw_w_accept accepts=%0d bresps=%0d want 1/1", acc, brise); end
  endtask

  task automatic test_simul();
    logic [31:0] d;
    @(negedge clk);
    awaddr = A_IER; wdata = 1; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    araddr = A_PHI; arvalid = 1; rready = 1;
    @(negedge clk);
    total++; if (!(awready && arready)) begin bad++; $display("FAIL simul_accept aw=%b ar=%b want 1/1", awready, arready); end
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    total++;
    if (!(bvalid && rvalid) || rdata !== 32'h2) begin bad++; $display("FAIL simul_resp b=%b r=%b rdata=%h want 1/1/2", bvalid, rvalid, rdata); end
    @(negedge clk);
    bready = 0; rready = 0;
    axi_read(A_IER, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL simul_ier got=%h want 1", d); end
    axi_write(A_IER, 32'h0, 4'hF);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int dr;
    stub_en = 0; go_man = 0; done_man = 0;
    axi_write(A_CTRL, 32'h1, 4'hF);
    go_man = 1;
    @(negedge clk);
    go_man = 0;
    #2 reset_n = 0;
    #1;
    total++;
    if ({go_0r, done_0a, interrupt, awready, bvalid, arready, rvalid} !== 7'b0 || pbase !== RB) begin
      bad++; $display("FAIL mid_reset outs=%b param=%h want 0/%h", {go_0r, done_0a, interrupt, awready, bvalid, arready, rvalid}, pbase, RB);
    end
    @(negedge clk);
    reset_n = 1;
    stub_en = 1;
    axi_read(A_CTRL, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL mid_ctrl got=%h want 4", d); end
    dr = dn_rise;
    axi_write(A_CTRL, 32'h1, 4'hF);
    repeat (10) @(negedge clk);
    total++; if (dn_rise - dr != 1) begin bad++; $display("FAIL mid_rerun rises=%0d want 1", dn_rise - dr); end
    axi_read(A_CTRL, d);
    total++; if (d !== 32'h6) begin bad++; $display("FAIL mid_rerun_ctrl got=%h want 6", d); end
  endtask

  initial begin
    test_reset();
    test_param();
    test_run();
    test_irq();
    test_busy();
    test_aw_only();
    test_simul();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
